branch_predictor_gshare: RTL

- Parametrised successor to the pipeline's fixed branch prediction unit: gshare direction predictor plus a direct-mapped branch target buffer (BTB).
- Fetch-stage lookup is combinational from PCF and gives a predicted next PC.
- Execute-stage update trains the counters, BTB and global history, and raises a mispredict flush with the recovery PC.
- Sits beside the hazard unit; drives the PC select mux and the flush input of the F/D and D/E registers.

---
 rtl/branch_predictor_gshare_if.sv | 40 ++++
 rtl/branch_predictor_gshare.sv | 120 ++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare_if.sv
// Fetch/execute interface of the gshare branch predictor.
// The pipeline side uses the master modport and the predictor uses the slave modport.
interface branch_predictor_gshare_if #(
    parameter int WIDTH = 32,
    parameter int IDX   = 4
);
    logic [WIDTH-1:0] PCF;
    logic             StallF;
    logic             PredTakenF;
    logic [WIDTH-1:0] PredTargetF;
    logic [IDX-1:0]   PredIdxF;

    logic             BranchE;
    logic             JumpE;
    logic             TakenE;
    logic [WIDTH-1:0] PCE;
    logic [WIDTH-1:0] TargetE;
    logic             PredTakenE;
    logic [WIDTH-1:0] PredTargetE;
    logic [IDX-1:0]   PredIdxE;
    logic             MispredictE;
    logic [WIDTH-1:0] RecoverPCE;

    logic [31:0]      BranchCount;
    logic [31:0]      MispredCount;

    modport master (
        output PCF, StallF, BranchE, JumpE, TakenE, PCE, TargetE,
               PredTakenE, PredTargetE, PredIdxE,
        input  PredTakenF, PredTargetF, PredIdxF, MispredictE, RecoverPCE,
               BranchCount, MispredCount
    );

    modport slave (
        input  PCF, StallF, BranchE, JumpE, TakenE, PCE, TargetE,
               PredTakenE, PredTargetE, PredIdxE,
        output PredTakenF, PredTargetF, PredIdxF, MispredictE, RecoverPCE,
               BranchCount, MispredCount
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor with a direct-mapped BTB. Lookup happens in fetch, and training happens in execute.
// Defining BPU_STATS_EN adds the resolved-branch and mispredict statistics counters.
module branch_predictor_gshare #(
    parameter int WIDTH     = 32,
    parameter int ENTRIES   = 16,
    parameter int HIST_BITS = 4,
    parameter int CTR_BITS  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    branch_predictor_gshare_if.slave bus
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = WIDTH - IDX - 2;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN  = '0;

    logic [CTR_BITS-1:0] ctr        [ENTRIES];
    logic [ENTRIES-1:0]  btb_valid;
    logic [TAG_W-1:0]    btb_tag    [ENTRIES];
    logic [WIDTH-1:0]    btb_target [ENTRIES];
    logic [ENTRIES-1:0]  btb_jump;
    logic [HIST_BITS-1:0] ghr;

    logic [IDX-1:0]   f_bidx;
    logic [IDX-1:0]   f_cidx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_taken;
    logic [IDX-1:0]   e_bidx;
    logic [TAG_W-1:0] e_tag;
    logic             e_any;
    logic             e_branch;
    logic             e_btb_wr;
    logic             unused_stall;

    // The lookup reads only current state. So a same-cycle update to the same entry becomes visible on the next cycle.
    assign f_bidx  = bus.PCF[IDX+1:2];
    assign f_cidx  = f_bidx ^ IDX'(ghr);
    assign f_tag   = bus.PCF[WIDTH-1:IDX+2];
    assign f_hit   = btb_valid[f_bidx] && (btb_tag[f_bidx] == f_tag);
    assign f_taken = f_hit && (btb_jump[f_bidx] || ctr[f_cidx][CTR_BITS-1]);

    assign bus.PredTakenF  = f_taken;
    assign bus.PredTargetF = f_taken ? btb_target[f_bidx] : bus.PCF + WIDTH'(4);
    assign bus.PredIdxF    = f_cidx;

    // When BranchE and JumpE are both set, the transfer is treated as a jump.
    assign e_any    = bus.BranchE | bus.JumpE;
    assign e_branch = bus.BranchE & ~bus.JumpE;
    assign e_btb_wr = e_any & bus.TakenE;
    assign e_bidx   = bus.PCE[IDX+1:2];
    assign e_tag    = bus.PCE[WIDTH-1:IDX+2];

    assign bus.MispredictE = e_any &&
                             ((bus.PredTakenE != bus.TakenE) ||
                              (bus.TakenE && (bus.PredTargetE != bus.TargetE)));
    assign bus.RecoverPCE  = bus.TakenE ? bus.TargetE : bus.PCE + WIDTH'(4);

    // A stalled fetch only holds PCF steady. The lookup has no state of its own to freeze.
    assign unused_stall = bus.StallF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= CTR_INIT;
            end
            btb_valid <= '0;
            btb_jump  <= '0;
            ghr       <= '0;
        end else begin
            if (e_branch) begin
                if (bus.TakenE) begin
                    if (ctr[bus.PredIdxE] != CTR_MAX)
                        ctr[bus.PredIdxE] <= ctr[bus.PredIdxE] + CTR_BITS'(1);
                end else begin
                    if (ctr[bus.PredIdxE] != CTR_MIN)
                        ctr[bus.PredIdxE] <= ctr[bus.PredIdxE] - CTR_BITS'(1);
                end
                ghr <= HIST_BITS'({ghr, bus.TakenE});
            end
            if (e_btb_wr) begin
                btb_valid[e_bidx] <= 1'b1;
                btb_jump[e_bidx]  <= bus.JumpE;
            end
        end
    end

    // The tag and target of an entry are meaningful only while its valid bit is set, so they need no reset.
    always_ff @(posedge clk) begin
        if (e_btb_wr) begin
            btb_tag[e_bidx]    <= e_tag;
            btb_target[e_bidx] <= bus.TargetE;
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (e_any)
                branch_cnt <= branch_cnt + 32'd1;
            if (bus.MispredictE)
                mispred_cnt <= mispred_cnt + 32'd1;
        end
    end

    assign bus.BranchCount  = branch_cnt;
    assign bus.MispredCount = mispred_cnt;
`else
    assign bus.BranchCount  = '0;
    assign bus.MispredCount = '0;
`endif
endmodule
